// File: rtl/sop_term_engine.sv
// Runtime-programmable sum-of-products / product-of-sums evaluator with a
// 2-stage result pipeline and an exhaustive-sweep minterm counter.
module sop_term_engine #(
   parameter int N_IN    = 9,
   parameter int N_TERMS = 12,
   parameter int IW      = $clog2(N_TERMS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [IW-1:0]      cfg_idx,
   input  logic               cfg_en,
   input  logic [N_IN-1:0]    cfg_care,
   input  logic [N_IN-1:0]    cfg_pol,
   input  logic               mode,
   input  logic               in_valid,
   input  logic [N_IN-1:0]    in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic               out,
   output logic [N_TERMS-1:0] term_hits,
   input  logic               sweep_start,
   output logic               sweep_busy,
   output logic               sweep_done,
   output logic [N_IN:0]      ones_count
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

   // Counter is one bit wider than the vector so the drain phase can keep
   // counting past the last issued value without wrapping.
   localparam logic [N_IN:0] SWEEP_LAST = {1'b0, {N_IN{1'b1}}};
   localparam logic [N_IN:0] DRAIN_LAST = SWEEP_LAST + (N_IN+1)'(2);

   state_t              state_q, state_d;
   logic [N_IN:0]       cnt_q, cnt_d;

   logic [N_TERMS-1:0]  en_q;
   logic [N_IN-1:0]     care_q [N_TERMS];
   logic [N_IN-1:0]     pol_q  [N_TERMS];

   logic                s1_valid_q, s1_sweep_q, s1_mode_q;
   logic [N_TERMS-1:0]  s1_hits_q;
   logic                out_valid_q, out_q;
   logic [N_TERMS-1:0]  term_hits_q;
   logic [N_IN:0]       ones_q;

   logic                sweeping, accept, issue, reduce_c;
   logic [N_IN-1:0]     vec_c;
   logic [N_TERMS-1:0]  hits_c;

   assign sweeping   = (state_q == S_SWEEP);
   assign sweep_busy = (state_q == S_SWEEP) || (state_q == S_DRAIN);
   assign sweep_done = (state_q == S_DONE);
   assign in_ready   = (state_q == S_IDLE) && !sweep_start;
   assign accept     = in_valid && in_ready;
   assign issue      = sweeping || accept;

   assign out_valid  = out_valid_q;
   assign out        = out_q;
   assign term_hits  = term_hits_q;
   assign ones_count = ones_q;

   // NOTE: the table is a reset register file, not RAM; rst must clear it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q <= '0;
         for (int t = 0; t < N_TERMS; t++) begin
            care_q[t] <= '0;
            pol_q[t]  <= '0;
         end
      end else if (cfg_we && !sweep_busy) begin
         for (int t = 0; t < N_TERMS; t++) begin
            if (cfg_idx == IW'(t)) begin
               en_q[t]   <= cfg_en;
               care_q[t] <= cfg_care;
               pol_q[t]  <= cfg_pol;
            end
         end
      end
   end

   // Disabled entries evaluate to the reduction's neutral element.
   always_comb begin
      vec_c  = sweeping ? cnt_q[N_IN-1:0] : in_data;
      hits_c = '0;
      for (int t = 0; t < N_TERMS; t++) begin
         if (mode)
            hits_c[t] = !en_q[t] || (|(care_q[t] & ~(vec_c ^ pol_q[t])));
         else
            hits_c[t] = en_q[t] && !(|(care_q[t] & (vec_c ^ pol_q[t])));
      end
   end

   assign reduce_c = s1_mode_q ? (&s1_hits_q) : (|s1_hits_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (sweep_start) begin
               state_d = S_SWEEP;
               cnt_d   = '0;
            end
         end
         S_SWEEP: begin
            cnt_d = cnt_q + (N_IN+1)'(1);
            if (cnt_q == SWEEP_LAST) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            cnt_d = cnt_q + (N_IN+1)'(1);
            if (cnt_q == DRAIN_LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sweep_q  <= 1'b0;
         s1_mode_q   <= 1'b0;
         s1_hits_q   <= '0;
         out_valid_q <= 1'b0;
         out_q       <= 1'b0;
         term_hits_q <= '0;
         ones_q      <= '0;
      end else begin
         s1_valid_q  <= issue;
         s1_sweep_q  <= sweeping;
         s1_mode_q   <= mode;
         s1_hits_q   <= hits_c;
         out_valid_q <= s1_valid_q && !s1_sweep_q;
         // Sweep results only feed the counter; out/term_hits keep the last external result.
         if (s1_valid_q && !s1_sweep_q) begin
            out_q       <= reduce_c;
            term_hits_q <= s1_hits_q;
         end
         if ((state_q == S_IDLE) && sweep_start)
            ones_q <= '0;
         else if (s1_valid_q && s1_sweep_q && reduce_c)
            ones_q <= ones_q + (N_IN+1)'(1);
      end
   end

endmodule

// File: tb/tb_sop_term_engine.sv
// Self-checking bench for sop_term_engine: randomized and directed vectors
// compared against a behavioural table model and the lab's golden function.
module tb_sop_term_engine;

   localparam int N_IN    = 9;
   localparam int N_TERMS = 12;
   localparam int IW      = $clog2(N_TERMS);
   localparam int NV      = 1 << N_IN;

   logic               clk = 1'b0;
   logic               rst;
   logic               cfg_we;
   logic [IW-1:0]      cfg_idx;
   logic               cfg_en;
   logic [N_IN-1:0]    cfg_care;
   logic [N_IN-1:0]    cfg_pol;
   logic               mode;
   logic               in_valid;
   logic [N_IN-1:0]    in_data;
   logic               in_ready;
   logic               out_valid;
   logic               out;
   logic [N_TERMS-1:0] term_hits;
   logic               sweep_start;
   logic               sweep_busy;
   logic               sweep_done;
   logic [N_IN:0]      ones_count;

   sop_term_engine #(.N_IN(N_IN), .N_TERMS(N_TERMS)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_care(cfg_care), .cfg_pol(cfg_pol),
      .mode(mode), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out(out), .term_hits(term_hits),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy),
      .sweep_done(sweep_done), .ones_count(ones_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit              m_en   [N_TERMS];
   logic [N_IN-1:0] m_care [N_TERMS];
   logic [N_IN-1:0] m_pol  [N_TERMS];

   function automatic void model(input logic [N_IN-1:0] v, input bit md,
                                 output bit o, output logic [N_TERMS-1:0] h);
      bit all_match, any_match;
      for (int t = 0; t < N_TERMS; t++) begin
         all_match = 1'b1;
         any_match = 1'b0;
         for (int i = 0; i < N_IN; i++) begin
            if (m_care[t][i]) begin
               if (v[i] == m_pol[t][i]) any_match = 1'b1;
               else                     all_match = 1'b0;
            end
         end
         if (!m_en[t]) h[t] = md;
         else          h[t] = md ? any_match : all_match;
      end
      o = md;
      for (int t = 0; t < N_TERMS; t++) o = md ? (o & h[t]) : (o | h[t]);
   endfunction

   function automatic int model_count(input bit md);
      bit o;
      logic [N_TERMS-1:0] h;
      int n;
      n = 0;
      for (int v = 0; v < NV; v++) begin
         model(N_IN'(v), md, o, h);
         if (o) n++;
      end
      return n;
   endfunction

   function automatic bit lab_sop(input logic [8:0] v);
      bit a, b, c, d, e, f, g, h, i;
      {i, h, g, f, e, d, c, b, a} = v;
      return a | b | (c&d&e) | (f&g&h) | (!a&!b&c) | (d&!f&g) | (a&b&!d) |
             (b&g&!h) | (a&b&c&d&e) | (a&b&i) | (a&c&e) | (!e&!f&!g);
   endfunction

   function automatic bit lab_pos(input logic [8:0] v);
      bit a, b, c, d, e, f, g, h, i;
      {i, h, g, f, e, d, c, b, a} = v;
      return a & b & (c|d|e) & (f|g|h) & (!a|!b|c) & (d|!f|g) & (a|b|!d) &
             (b|g|!h) & (a|b|c|d|e) & (a|b|i) & (a|c|e) & (!e|!f|!g);
   endfunction

   function automatic int lab_count(input bit md);
      int n;
      n = 0;
      for (int v = 0; v < NV; v++) if (md ? lab_pos(N_IN'(v)) : lab_sop(N_IN'(v))) n++;
      return n;
   endfunction

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      bit                 o;
      logic [N_TERMS-1:0] h;
   } exp_t;

   exp_t               exp_q[$];
   bit                 last_o;
   logic [N_TERMS-1:0] last_h;
   int                 n_valid = 0;

   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (!rst && out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
               e = exp_q.pop_front();
               check("out", out, e.o);
               check("term_hits", term_hits, e.h);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic push_exp(input logic [N_IN-1:0] v, input bit md, input int force_o);
      exp_t e;
      model(v, md, e.o, e.h);
      if (force_o >= 0) e.o = force_o[0];
      exp_q.push_back(e);
      last_o = e.o;
      last_h = e.h;
   endtask

   task automatic send(input logic [N_IN-1:0] v, input bit md, input int force_o);
      in_valid = 1'b1;
      in_data  = v;
      mode     = md;
      if (in_ready) push_exp(v, md, force_o);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic write_entry(input int idx, input bit en,
                              input logic [N_IN-1:0] care, input logic [N_IN-1:0] pol);
      cfg_we   = 1'b1;
      cfg_idx  = IW'(idx);
      cfg_en   = en;
      cfg_care = care;
      cfg_pol  = pol;
      if (!sweep_busy && idx < N_TERMS) begin
         m_en[idx]   = en;
         m_care[idx] = care;
         m_pol[idx]  = pol;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic clear_model();
      for (int t = 0; t < N_TERMS; t++) begin
         m_en[t]   = 1'b0;
         m_care[t] = '0;
         m_pol[t]  = '0;
      end
   endtask

   // Runs one sweep; optionally offers a vector with sweep_start and/or
   // attempts a table write mid-sweep. Expected count is computed by caller.
   task automatic run_sweep(input string tag, input bit md, input int exp_count,
                            input bit with_valid, input bit with_write);
      int n;
      mode        = md;
      sweep_start = 1'b1;
      in_valid    = with_valid;
      in_data     = N_IN'($urandom);
      #1;
      check({tag, "_in_ready_at_start"}, in_ready, 0);
      @(posedge clk); #1;
      sweep_start = 1'b0;
      in_valid    = 1'b0;
      check({tag, "_busy"}, sweep_busy, 1);
      n = 0;
      while (!sweep_done && n < 600) begin
         if (with_write && n == 10) begin
            cfg_we = 1'b1; cfg_idx = IW'(5); cfg_en = 1'b1; cfg_care = '0; cfg_pol = '0;
         end else cfg_we = 1'b0;
         @(posedge clk); #1;
         n++;
      end
      cfg_we = 1'b0;
      // sweep_done is seen in the cycle that ends at edge s + NV + 3
      check({tag, "_done_latency"}, n, NV + 2);
      check({tag, "_ones_count"}, ones_count, exp_count);
      check({tag, "_busy_low_at_done"}, sweep_busy, 0);
      check({tag, "_in_ready_at_done"}, in_ready, 0);
      check({tag, "_out_held"}, out, last_o);
      check({tag, "_hits_held"}, term_hits, last_h);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, sweep_done, 0);
      check({tag, "_in_ready_after"}, in_ready, 1);
      mode = 1'b0;
   endtask

   task automatic program_lab();
      write_entry(0,  1, 9'h001, 9'h001);  // a
      write_entry(1,  1, 9'h002, 9'h002);  // b
      write_entry(2,  1, 9'h01C, 9'h01C);  // cde
      write_entry(3,  1, 9'h0E0, 9'h0E0);  // fgh
      write_entry(4,  1, 9'h007, 9'h004);  // a'b'c
      write_entry(5,  1, 9'h068, 9'h048);  // df'g
      write_entry(6,  1, 9'h00B, 9'h003);  // abd'
      write_entry(7,  1, 9'h0C2, 9'h042);  // bgh'
      write_entry(8,  1, 9'h01F, 9'h01F);  // abcde
      write_entry(9,  1, 9'h103, 9'h103);  // abi
      write_entry(10, 1, 9'h015, 9'h015);  // ace
      write_entry(11, 1, 9'h070, 9'h000);  // e'f'g'
   endtask

   task automatic wait_drain();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v0;
      bit seen_done;
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_care = '0; cfg_pol = '0;
      mode = 1'b0; in_valid = 1'b0; in_data = '0; sweep_start = 1'b0;
      last_o = 1'b0; last_h = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      check("rst_term_hits", term_hits, 0);
      check("rst_busy", sweep_busy, 0);
      check("rst_done", sweep_done, 0);
      check("rst_ones_count", ones_count, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single literal term, latency check
      write_entry(0, 1, 9'h001, 9'h001);
      in_valid = 1'b1; in_data = 9'h001; mode = 1'b0;
      push_exp(9'h001, 0, -1);
      @(posedge clk); #1;
      check("lat_not_yet", out_valid, 0);
      in_data = 9'h000;
      push_exp(9'h000, 0, -1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_v1_valid", out_valid, 1);
      check("lat_v1_out", out, 1);
      check("lat_v1_hits", term_hits, 12'h001);
      @(posedge clk); #1;
      check("lat_v0_valid", out_valid, 1);
      check("lat_v0_out", out, 0);
      check("lat_v0_hits", term_hits, 12'h000);
      wait_drain();

      // Lab table, full back-to-back stream against the golden function
      program_lab();
      v0 = n_valid;
      for (int v = 0; v < NV; v++) send(N_IN'(v), 0, int'(lab_sop(N_IN'(v))));
      wait_drain();
      check("stream_valid_count", n_valid - v0, NV);

      run_sweep("sweep_sop", 0, lab_count(0), 0, 0);
      run_sweep("sweep_pos", 1, lab_count(1), 0, 0);

      // POS stream against the golden product of clauses
      for (int k = 0; k < 64; k++) begin
         v0 = int'($urandom_range(NV - 1));
         send(N_IN'(v0), 1, int'(lab_pos(N_IN'(v0))));
      end
      wait_drain();

      // Random tables, random mode, random gaps
      for (int r = 0; r < 3; r++) begin
         for (int t = 0; t < N_TERMS; t++)
            write_entry(t, ($urandom_range(3) != 0), N_IN'($urandom) & N_IN'($urandom),
                        N_IN'($urandom));
         for (int k = 0; k < 100; k++) begin
            send(N_IN'($urandom), $urandom_range(1) == 1, -1);
            if ($urandom_range(3) == 0) begin
               @(posedge clk); #1;
            end
         end
         wait_drain();
      end

      // Write attempted mid-sweep must be ignored
      run_sweep("sweep_wr_blocked", 0, model_count(0), 0, 1);
      for (int k = 0; k < 20; k++) send(N_IN'($urandom), 0, -1);
      wait_drain();

      // Reset 100 cycles into a sweep
      mode = 1'b0;
      sweep_start = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      clear_model();
      exp_q.delete();
      last_o = 1'b0; last_h = '0;
      check("abort_out_valid", out_valid, 0);
      check("abort_out", out, 0);
      check("abort_hits", term_hits, 0);
      check("abort_busy", sweep_busy, 0);
      check("abort_done", sweep_done, 0);
      check("abort_ones_count", ones_count, 0);
      check("abort_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (NV + 20) begin
         @(posedge clk); #1;
         if (sweep_done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);

      // Empty table boundaries
      run_sweep("empty_sop", 0, 0, 0, 0);
      run_sweep("empty_pos", 1, NV, 0, 0);

      // Out-of-range index ignored
      write_entry(13, 1, '0, '0);
      send(N_IN'($urandom), 0, 0);
      wait_drain();

      // Write and vector in the same cycle: old table, then new table
      in_valid = 1'b1; in_data = N_IN'($urandom); mode = 1'b0;
      push_exp(in_data, 0, 0);
      cfg_we = 1'b1; cfg_idx = IW'(3); cfg_en = 1'b1; cfg_care = '0; cfg_pol = '0;
      m_en[3] = 1'b1; m_care[3] = '0; m_pol[3] = '0;
      @(posedge clk); #1;
      cfg_we  = 1'b0;
      in_data = N_IN'($urandom);
      push_exp(in_data, 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain();

      // Constant-1 term: every vector yields 1
      for (int v = 0; v < NV; v++) send(N_IN'(v), 0, 1);
      wait_drain();

      // sweep_start wins over in_valid; the offered vector must not appear
      run_sweep("start_vs_valid", 0, NV, 1, 0);
      wait_drain();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sop_term_engine.md
# sop_term_engine

Programmable, parametrised sum-of-products / product-of-sums evaluator for the Boolean-algebra lab designs. A runtime-loadable table of N_TERMS product terms over N_IN inputs replaces hard-wired gate networks. Vectors flow through a 2-stage registered pipeline. A built-in sweep FSM enumerates all 2^N_IN input combinations and counts how many drive the output high. It sits between the lab's switch/stimulus logic and the result display/compare logic.

## Interface
- N_IN, 9, number of Boolean inputs (1..16)
- N_TERMS, 12, number of programmable terms (2..32)
- IW, $clog2(N_TERMS), derived term-index width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  write one table entry this cycle
- cfg_idx  in  IW  entry index; writes with cfg_idx >= N_TERMS are ignored
- cfg_en  in  1  entry enable
- cfg_care  in  N_IN  literal-present mask
- cfg_pol  in  N_IN  literal polarity (1 = true literal, 0 = complemented)
- mode  in  1  0 = SOP, 1 = POS; sampled with each accepted vector
- in_valid  in  1  external vector offered
- in_data  in  N_IN  external vector
- in_ready  out  1  vector accepted when in_valid && in_ready
- out_valid  out  1  one-cycle pulse per external result
- out  out  1  function result
- term_hits  out  N_TERMS  per-term results aligned with out
- sweep_start  in  1  begin exhaustive sweep (IDLE only)
- sweep_busy  out  1  high in SWEEP and DRAIN
- sweep_done  out  1  one-cycle pulse when ones_count is final
- ones_count  out  N_IN+1  count of inputs with out = 1 from the last sweep

## Operation
- Term t, SOP mode: hit iff en[t] && every i with care[i]=1 has in[i]==pol[i]. An enabled term with care=0 is constant 1. out = OR of hits; 0 if no term is enabled.
- Term t, POS mode: clause is true iff some i with care[i]=1 has in[i]==pol[i]. A disabled entry reports 1. An enabled entry with care=0 is constant 0. out = AND of the term_hits bits; 1 if no term is enabled.
- Stage 1 registers term_hits, mode and tag (external/sweep). Stage 2 registers the reduction.
- Table writes take effect on the clock edge. A vector accepted in the same cycle as a write uses the pre-write table.
- cfg_we is ignored while sweep_busy.
- FSM states:
  - IDLE -> SWEEP on sweep_start. The same cycle clears ones_count and loads counter = 0.
  - SWEEP: one counter value enters the pipeline per cycle, tagged sweep, using the current mode. After value 2^N_IN-1 is issued -> DRAIN.
  - DRAIN: 2 cycles for the last results to retire -> DONE.
  - DONE: sweep_done = 1 for one cycle -> IDLE.
- in_ready = (state==IDLE) && !sweep_start. sweep_start has priority over in_valid.
- Sweep-tagged results:
  - increment ones_count when out = 1;
  - never raise out_valid;
  - leave out and term_hits holding their last external result.
- External vectors already in flight when a sweep starts retire normally with out_valid.
- ones_count holds its value until the next sweep_start.

## Timing
- Reset values: table all zero (en, care, pol); state IDLE; all pipeline valids 0; in_ready 1; out_valid, out, term_hits, sweep_busy, sweep_done, ones_count all 0.
- External latency: a vector accepted at edge k gives out, term_hits and out_valid at edge k+2. Full throughput: 1 vector per cycle, no output backpressure.
- Sweep: sweep_start sampled at edge s gives sweep_busy high from s+1 through s+2^N_IN+2. sweep_done pulses at edge s+2^N_IN+3. in_ready returns at the same edge.
- The counter is N_IN+1 bits wide so the terminal value is detected without wrap. ones_count can reach 2^N_IN without overflow.
- rst mid-sweep aborts immediately: IDLE, count 0, table cleared, no sweep_done.

## Test plan
- Reset, then N_IN=9, SOP: write entry 0 {en=1, care=0x001, pol=0x001}. Vectors 0x001 and 0x000 -> out 1 then 0, each 2 cycles after acceptance; term_hits = 0x001 then 0x000.
- Program entries 0..11 with the lab's 12-term function: a; b; cde; fgh; a'b'c; df'g; abd'; bgh'; abcde; abi; ace; e'f'g'. Stream all 512 vectors back-to-back -> every result matches the golden SOP, one out_valid per cycle.
- Same table, sweep_start -> sweep_done at cycle 515 after start; ones_count equals the golden minterm count. Repeat with mode=1 and compare against the golden POS count.
- Empty table: SOP sweep -> ones_count 0. POS sweep -> ones_count 512. Entry 3 {en=1, care=0} in SOP -> out 1 for every vector.
- Assert cfg_we and in_valid in the same cycle -> the vector uses the old table and the next vector uses the new one. Assert sweep_start and in_valid together -> in_ready 0, vector not accepted. Assert cfg_we during sweep -> table unchanged.
- Assert rst 100 cycles into a sweep -> all outputs 0 the next cycle, no sweep_done, in_ready 1.
